// File: rtl/quad_adc_if.sv
// Deserializer for one channel of a quad 2-lane DDR 14-bit ADC: rebuilds one word per 4-cycle frame.
// Optional sticky framing-error detection is built when QUAD_ADC_FRAME_CHECK_EN is defined.
`timescale 1ns/1ps
module quad_adc_if (
    input  logic        DATA_CLK,
    input  logic        RESET_N,
    input  logic        FRAME_CLK,
    input  logic        CH_X_A,
    input  logic        CH_X_B,
    output logic [13:0] CH_X_DATA,
    output logic        DATA_VALID
`ifdef QUAD_ADC_FRAME_CHECK_EN
    ,
    output logic        FRAME_ERR
`endif
);

    logic        r_fall_a_p0;
    logic        r_fall_b_p0;
    logic        r_fc_prev;
    logic        r_busy;
    logic [1:0]  r_slot;
    logic [13:0] r_shift;
    logic [13:0] r_data;
    logic        r_valid;
    logic        w_start;

    // Stage 0: falling-edge lane capture, consumed at the following rising edge
    always_ff @(negedge DATA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_fall_a_p0 <= 1'b0;
            r_fall_b_p0 <= 1'b0;
        end else begin
            r_fall_a_p0 <= CH_X_A;
            r_fall_b_p0 <= CH_X_B;
        end
    end

    assign w_start = FRAME_CLK & ~r_fc_prev;

    // Stage 1: rising-edge assembly; each rising edge after the start appends a fall pair and a rise pair
    always_ff @(posedge DATA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_fc_prev <= 1'b1;
            r_busy    <= 1'b0;
            r_slot    <= 2'd3;
            r_shift   <= 14'd0;
            r_data    <= 14'd0;
            r_valid   <= 1'b0;
        end else begin
            r_fc_prev <= FRAME_CLK;
            r_valid   <= 1'b0;
            if (r_busy && (r_slot == 2'd3)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end
            if (w_start) begin
                r_busy  <= 1'b1;
                r_slot  <= 2'd0;
                r_shift <= {12'd0, CH_X_A, CH_X_B};
            end else if (r_busy) begin
                if (r_slot == 2'd3) begin
                    r_busy <= 1'b0;
                end else begin
                    r_slot  <= r_slot + 2'd1;
                    r_shift <= {r_shift[9:0], r_fall_a_p0, r_fall_b_p0, CH_X_A, CH_X_B};
                end
            end
        end
    end

    assign CH_X_DATA  = r_data;
    assign DATA_VALID = r_valid;

`ifdef QUAD_ADC_FRAME_CHECK_EN
    // r_since: rising edges since the last start; 0 means no start seen yet, 7 saturates
    logic [2:0] r_since;
    logic       r_bad;
    logic       r_err;

    always_ff @(posedge DATA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_since <= 3'd0;
            r_bad   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_since <= 3'd1;
            end else if ((r_since != 3'd0) && (r_since != 3'd7)) begin
                r_since <= r_since + 3'd1;
            end
            r_bad <= w_start && (r_since != 3'd0) && (r_since != 3'd4);
            r_err <= r_err | r_bad;
        end
    end

    assign FRAME_ERR = r_err;
`endif

endmodule

// File: tb/tb_quad_adc_if.sv
// Self-checking bench for quad_adc_if: directed framing scenarios with random sample words and pads.
`timescale 1ns/1ps
module tb_quad_adc_if;

    logic        DATA_CLK  = 1'b0;
    logic        RESET_N   = 1'b1;
    logic        FRAME_CLK = 1'b0;
    logic        CH_X_A    = 1'b0;
    logic        CH_X_B    = 1'b0;
    wire  [13:0] CH_X_DATA;
    wire         DATA_VALID;
`ifdef QUAD_ADC_FRAME_CHECK_EN
    wire         FRAME_ERR;
`endif

    quad_adc_if dut (
        .DATA_CLK   (DATA_CLK),
        .RESET_N    (RESET_N),
        .FRAME_CLK  (FRAME_CLK),
        .CH_X_A     (CH_X_A),
        .CH_X_B     (CH_X_B),
        .CH_X_DATA  (CH_X_DATA),
        .DATA_VALID (DATA_VALID)
`ifdef QUAD_ADC_FRAME_CHECK_EN
        ,
        .FRAME_ERR  (FRAME_ERR)
`endif
    );

    always #25 DATA_CLK = ~DATA_CLK;

    int errors = 0;
    int checks = 0;

    logic [13:0] exp_w[$];
    longint      exp_t[$];
    logic [13:0] obs_w[$];
    longint      obs_t[$];

    always @(negedge DATA_CLK) begin
        if (DATA_VALID === 1'b1) begin
            obs_w.push_back(CH_X_DATA);
            obs_t.push_back(longint'($time));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Pair k (1..7) carries A = D[15-2k], B = D[14-2k]; pair 8 is the pad.
    task automatic drive_pair(input logic [13:0] w, input int k, input logic [1:0] pad);
        if (k == 8) begin
            CH_X_A = pad[1];
            CH_X_B = pad[0];
        end else begin
            CH_X_A = w[15-2*k];
            CH_X_B = w[14-2*k];
        end
    endtask

    // Called 5 ns after a falling edge; returns 5 ns after the falling edge that ends the frame.
    task automatic send_frame(input logic [13:0] w, input logic [1:0] pad);
        longint t0;
        FRAME_CLK = 1'b1;
        drive_pair(w, 1, pad);
        @(posedge DATA_CLK);
        t0 = longint'($time);
        #5 drive_pair(w, 2, pad);
        @(negedge DATA_CLK); #5 drive_pair(w, 3, pad);
        @(posedge DATA_CLK); #5 drive_pair(w, 4, pad);
        @(negedge DATA_CLK); #5 FRAME_CLK = 1'b0; drive_pair(w, 5, pad);
        @(posedge DATA_CLK); #5 drive_pair(w, 6, pad);
        @(negedge DATA_CLK); #5 drive_pair(w, 7, pad);
        @(posedge DATA_CLK); #5 drive_pair(w, 8, pad);
        @(negedge DATA_CLK); #5;
        exp_w.push_back(w);
        exp_t.push_back(t0 + 64'd225);
    endtask

    // FRAME_CLK high 2T, low 1T; the next frame then starts one rising edge early.
    task automatic send_trunc(input logic [13:0] w);
        FRAME_CLK = 1'b1;
        drive_pair(w, 1, 2'b00);
        @(posedge DATA_CLK); #5 drive_pair(w, 2, 2'b00);
        @(negedge DATA_CLK); #5 drive_pair(w, 3, 2'b00);
        @(posedge DATA_CLK); #5 drive_pair(w, 4, 2'b00);
        @(negedge DATA_CLK); #5 FRAME_CLK = 1'b0; drive_pair(w, 5, 2'b00);
        @(posedge DATA_CLK); #5 drive_pair(w, 6, 2'b00);
        @(negedge DATA_CLK); #5;
    endtask

    task automatic idle(input int n);
        FRAME_CLK = 1'b0;
        for (int i = 0; i < n; i++) begin
            CH_X_A = 1'($urandom);
            CH_X_B = 1'($urandom);
            @(posedge DATA_CLK); #5;
            CH_X_A = 1'($urandom);
            CH_X_B = 1'($urandom);
            @(negedge DATA_CLK); #5;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        chk({tag, "_count"}, obs_w.size(), exp_w.size());
        n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_word"}, obs_w[i], exp_w[i]);
            chk({tag, "_time"}, obs_t[i][31:0], exp_t[i][31:0]);
        end
        obs_w.delete(); obs_t.delete();
        exp_w.delete(); exp_t.delete();
    endtask

    initial begin
        logic [13:0] wr;

        #1 RESET_N = 1'b0;
        #1;
        chk("reset_data", CH_X_DATA, 0);
        chk("reset_valid", DATA_VALID, 0);
`ifdef QUAD_ADC_FRAME_CHECK_EN
        chk("reset_err", FRAME_ERR, 0);
`endif
        repeat (2) @(negedge DATA_CLK);
        #5 RESET_N = 1'b1;
        idle(3);

        for (int i = 1; i <= 7; i++) send_frame(14'(i), 2'b00);
        for (int i = 0; i < 100; i++) send_frame(14'($urandom_range(0, 16383)), 2'($urandom));
        idle(3);
        drain("seq");
`ifdef QUAD_ADC_FRAME_CHECK_EN
        chk("clean_err", FRAME_ERR, 0);
`endif

        send_frame(14'h2AAA, 2'b11);
        send_frame(14'h1555, 2'b11);
        send_frame(14'h3FFF, 2'b11);
        send_frame(14'h0000, 2'b11);
        idle(3);
        drain("bitorder");

        for (int i = 0; i < 4; i++) send_frame(14'($urandom_range(0, 16383)), 2'($urandom));
        send_frame(14'h0005, 2'b00);
        idle(2);
        drain("pre_stop");
        for (int i = 0; i < 22; i++) begin
            @(negedge DATA_CLK);
            chk("stop_hold", CH_X_DATA, 14'h0005);
            chk("stop_valid", DATA_VALID, 0);
        end
        #5;

        wr = 14'($urandom_range(0, 16383));
        FRAME_CLK = 1'b1;
        drive_pair(wr, 1, 2'b00);
        @(posedge DATA_CLK); #5 drive_pair(wr, 2, 2'b00);
        @(negedge DATA_CLK); #5 drive_pair(wr, 3, 2'b00);
        @(posedge DATA_CLK); #5 RESET_N = 1'b0;
        #1;
        chk("midrst_data", CH_X_DATA, 0);
        chk("midrst_valid", DATA_VALID, 0);
`ifdef QUAD_ADC_FRAME_CHECK_EN
        chk("midrst_err", FRAME_ERR, 0);
`endif
        @(negedge DATA_CLK); #5 RESET_N = 1'b1;
        @(posedge DATA_CLK); #5;
        @(negedge DATA_CLK); #5;
        idle(3);
        drain("post_rst");

        send_trunc(14'($urandom_range(0, 16383)));
        send_frame(14'($urandom_range(0, 16383)), 2'($urandom));
        send_frame(14'($urandom_range(0, 16383)), 2'($urandom));
        idle(3);
        drain("trunc");
`ifdef QUAD_ADC_FRAME_CHECK_EN
        chk("trunc_err", FRAME_ERR, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
